// File: rtl/bcd_digit_encoder.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/done handshake.
// Optional two's-complement input support enabled by defining NEG_SIGN_EN.
module bcd_digit_encoder #(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [3:0]        ones,
  output logic [3:0]        tens,
  output logic [3:0]        hundreds,
  output logic [3:0]        thousands,
  output logic              ovf,
  output logic              neg
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [15:0]       scratch_q, scratch_d;
  logic [4:0]        count_q, count_d;
  logic              ovf_n_q, ovf_n_d;
  logic              neg_n_q, neg_n_d;
  logic [15:0]       digits_q, digits_d;
  logic              ovf_q, ovf_d;
  logic              neg_q, neg_d;

  logic [DATA_W-1:0] mag;
  logic              sign;
  logic [16:0]       mag_ext;
  logic [15:0]       adj;

  always_comb begin
`ifdef NEG_SIGN_EN
    sign = bin[DATA_W-1];
    mag  = sign ? -bin : bin;
`else
    sign = 1'b0;
    mag  = bin;
`endif
    mag_ext = {{(17-DATA_W){1'b0}}, mag};
  end

  // One double-dabble step: correct every nibble, then shift the combined register.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    ovf_n_d   = ovf_n_q;
    neg_n_d   = neg_n_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = mag;
          scratch_d = 16'h0000;
          count_d   = 5'(DATA_W);
          ovf_n_d   = (mag_ext > 17'd9999);
          neg_n_d   = sign;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[14:0], shreg_q[DATA_W-1]};
        shreg_d   = shreg_q << 1;
        count_d   = count_q - 5'd1;
        // Results are loaded on the edge into DONE so they are valid while done is high.
        if (count_q == 5'd1) begin
          state_d  = DONE;
          digits_d = ovf_n_q ? 16'h9999 : {adj[14:0], shreg_q[DATA_W-1]};
          ovf_d    = ovf_n_q;
          neg_d    = neg_n_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= 16'h0000;
      count_q   <= 5'd0;
      ovf_n_q   <= 1'b0;
      neg_n_q   <= 1'b0;
      digits_q  <= 16'h0000;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      ovf_n_q   <= ovf_n_d;
      neg_n_q   <= neg_n_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ones      = digits_q[3:0];
  assign tens      = digits_q[7:4];
  assign hundreds  = digits_q[11:8];
  assign thousands = digits_q[15:12];
  assign ovf       = ovf_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Randomised self-checking bench for bcd_digit_encoder against an arithmetic model.
// Honours NEG_SIGN_EN in the reference model when the macro is defined.
module tb_bcd_digit_encoder;

  localparam int W    = 14;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [3:0]   ones;
  logic [3:0]   tens;
  logic [3:0]   hundreds;
  logic [3:0]   thousands;
  logic         ovf;
  logic         neg;

  int checks = 0;
  int errors = 0;

  bcd_digit_encoder #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .thousands(thousands),
    .ovf      (ovf),
    .neg      (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Decimal digits computed directly from the input value.
  function automatic void model(input int b, output int d0, output int d1,
                                output int d2, output int d3,
                                output int o, output int n);
    int mag;
    mag = b;
    n   = 0;
`ifdef NEG_SIGN_EN
    if (b >= HALF) begin
      mag = FULL - b;
      n   = 1;
    end
`endif
    o = (mag > 9999) ? 1 : 0;
    if (o == 1) mag = 9999;
    d0 = mag % 10;
    d1 = (mag / 10) % 10;
    d2 = (mag / 100) % 10;
    d3 = (mag / 1000) % 10;
  endfunction

  task automatic checkDigits(input string tag, input int value);
    int d0, d1, d2, d3, o, n;
    model(value, d0, d1, d2, d3, o, n);
    checkOutput({tag, "_ones"}, int'(ones), d0);
    checkOutput({tag, "_tens"}, int'(tens), d1);
    checkOutput({tag, "_hundreds"}, int'(hundreds), d2);
    checkOutput({tag, "_thousands"}, int'(thousands), d3);
    checkOutput({tag, "_ovf"}, int'(ovf), o);
    checkOutput({tag, "_neg"}, int'(neg), n);
  endtask

  // Issue one conversion; optionally poke a second start mid-flight.
  task automatic applyStimulus(input string tag, input int value,
                               input int poke_cycle, input int poke_value);
    int cyc;
    bin   = W'(value);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 40) begin
      checkOutput({tag, "_busy"}, int'(busy), 1);
      if (cyc == poke_cycle) begin
        start = 1'b1;
        bin   = W'(poke_value);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, W + 1);
    checkOutput({tag, "_busy_at_done"}, int'(busy), 1);
    checkDigits(tag, value);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, int'(done), 0);
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int v, gap, poke;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkDigits("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("zero", 0, -1, 0);
    applyStimulus("v1234", 1234, -1, 0);
    repeat (20) begin
      @(posedge clk);
      #1;
      checkOutput("hold_done", int'(done), 0);
    end
    checkDigits("hold", 1234);

    applyStimulus("v9999", 9999, -1, 0);
    applyStimulus("v10000", 10000, -1, 0);
    applyStimulus("v16383", 16383, -1, 0);

    applyStimulus("v507", 507, 3, 42);
    applyStimulus("v42b2b", 42, -1, 0);

    // Reset in the middle of a conversion must abort without a done pulse.
    bin   = W'(8888);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkDigits("abort", 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("abort_done", int'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_idle_done", int'(done), 0);
    applyStimulus("after_abort", 42, -1, 0);

    applyStimulus("neg42", 16342, -1, 0);
    applyStimulus("most_neg", 8192, -1, 0);
    applyStimulus("zero_again", 0, -1, 0);

    for (int i = 0; i < 200; i++) begin
      v    = int'($urandom_range(0, FULL - 1));
      gap  = int'($urandom_range(0, 3));
      poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : -1;
      repeat (gap) begin
        @(posedge clk);
        #1;
        checkOutput("gap_done", int'(done), 0);
      end
      applyStimulus("rand", v, poke, int'($urandom_range(0, FULL - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
